param_reg_fifo: RTL and testbench

PARAM_REG_FIFO -- requirements
Module: param_reg_fifo

---
 rtl/param_reg_fifo.sv | 101 ++++++++++
 tb/tb_param_reg_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_fifo.sv
// Register-based FIFO with show-ahead read data, registered status flags and sticky error flags.
// Optional empty-FIFO write-to-read bypass when PARAM_REG_FIFO_BYPASS_EN is defined.
module param_reg_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iWrEn,
    input  logic [WIDTH-1:0]             iWrDat,
    input  logic                         iRdEn,
    output logic                         oFul,
    output logic                         oAlmFul,
    output logic                         oEmpty,
    output logic [$clog2(DEPTH+1)-1:0]   oCnt,
    output logic [WIDTH-1:0]             oRdDat,
    output logic                         oOvf,
    output logic                         oUdf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q, alm_ful_q;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic             byp_take;

`ifdef PARAM_REG_FIFO_BYPASS_EN
    // A word written and read in the same cycle while empty never touches storage.
    assign byp_take = empty_q & iWrEn & iRdEn;
    assign oRdDat   = (empty_q & iWrEn) ? iWrDat : mem_q[rd_ptr_q];
`else
    assign byp_take = 1'b0;
    assign oRdDat   = mem_q[rd_ptr_q];
`endif

    // NOTE: every signal gets a default at the top of always_comb so no latch can be inferred.
    always_comb begin
        wr_acc   = iWrEn & ~full_q & ~byp_take;
        rd_acc   = iRdEn & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (iWrEn & full_q);
        udf_d    = udf_q | (iRdEn & empty_q & ~byp_take);

        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Flags are derived from the next count so they stay aligned with oCnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            alm_ful_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            full_q    <= (cnt_d == FULL_CNT);
            empty_q   <= (cnt_d == '0);
            alm_ful_q <= (cnt_d >= AF_CNT);
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // NOTE: storage has no reset; its content is only observable after a write, so a reset would be wasted logic.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= iWrDat;
    end

    assign oFul    = full_q;
    assign oAlmFul = alm_ful_q;
    assign oEmpty  = empty_q;
    assign oCnt    = cnt_q;
    assign oOvf    = ovf_q;
    assign oUdf    = udf_q;

endmodule

// File: tb/tb_param_reg_fifo.sv
// Self-checking bench for param_reg_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional async resets.
module tb_param_reg_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int AF_LVL = 3;
    localparam int CW     = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             iWrEn = 1'b0;
    logic [WIDTH-1:0] iWrDat = '0;
    logic             iRdEn = 1'b0;
    logic             oFul, oAlmFul, oEmpty, oOvf, oUdf;
    logic [CW-1:0]    oCnt;
    logic [WIDTH-1:0] oRdDat;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    param_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clk(clk), .rst(rst), .iWrEn(iWrEn), .iWrDat(iWrDat), .iRdEn(iRdEn),
        .oFul(oFul), .oAlmFul(oAlmFul), .oEmpty(oEmpty), .oCnt(oCnt),
        .oRdDat(oRdDat), .oOvf(oOvf), .oUdf(oUdf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding the stored words plus the two sticky flags.
    logic [WIDTH-1:0] mq [$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit was_full, was_empty, consumed;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            consumed  = 1'b0;
`ifdef PARAM_REG_FIFO_BYPASS_EN
            consumed  = was_empty && iWrEn && iRdEn;
`endif
            if (iWrEn && was_full) m_ovf = 1'b1;
            if (iRdEn && was_empty && !consumed) m_udf = 1'b1;
            if (iRdEn && !was_empty) void'(mq.pop_front());
            if (iWrEn && !was_full && !consumed) mq.push_back(iWrDat);
        end
    end

    // Compare process: outputs are stable mid-cycle; inputs change 2 time units after the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cnt",    32'(oCnt),    32'(mq.size()));
            check("empty",  32'(oEmpty),  32'(mq.size() == 0));
            check("full",   32'(oFul),    32'(mq.size() == DEPTH));
            check("almful", 32'(oAlmFul), 32'(mq.size() >= AF_LVL));
            check("ovf",    32'(oOvf),    32'(m_ovf));
            check("udf",    32'(oUdf),    32'(m_udf));
            if (mq.size() != 0) check("rddat", 32'(oRdDat), 32'(mq[0]));
`ifdef PARAM_REG_FIFO_BYPASS_EN
            else if (iWrEn) check("bypass_dat", 32'(oRdDat), 32'(iWrDat));
`endif
        end
    end

    // Drive one cycle of inputs, then return 2 time units after the following rising edge.
    task automatic cyc(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        iWrEn  = wr;
        iWrDat = d;
        iRdEn  = rd;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        iWrEn = 1'b0;
        iRdEn = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        #2;
        check("rst_empty", 32'(oEmpty), 32'd1);
        check("rst_cnt",   32'(oCnt),   32'd0);
        check("rst_flags", {28'd0, oFul, oAlmFul, oOvf, oUdf}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Fill 0x01..0x04: count climbs, almost-full at 3, full at 4.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, WIDTH'(i), 1'b0);
            check("fill_cnt",    32'(oCnt),    32'(i));
            check("fill_almful", 32'(oAlmFul), (i >= 3) ? 32'd1 : 32'd0);
            check("fill_full",   32'(oFul),    (i == 4) ? 32'd1 : 32'd0);
            check("fill_ovf",    32'(oOvf),    32'd0);
        end

        // Overflow write is dropped, then drain in order.
        cyc(1'b1, 8'h05, 1'b0);
        check("ovf_set", 32'(oOvf), 32'd1);
        check("ovf_cnt", 32'(oCnt), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_dat", 32'(oRdDat), 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", 32'(oEmpty), 32'd1);

        // Steady read+write at occupancy 2 across pointer wrap.
        do_reset();
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, WIDTH'(8'h22 + i), 1'b1);
            check("steady_cnt", 32'(oCnt),   32'd2);
            check("steady_dat", 32'(oRdDat), 32'(8'h21 + i));
            check("steady_flg", {30'd0, oOvf, oUdf}, 32'd0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("steady_empty", 32'(oEmpty), 32'd1);

        // Read while empty.
`ifdef PARAM_REG_FIFO_BYPASS_EN
        iWrEn  = 1'b1;
        iWrDat = 8'hAA;
        iRdEn  = 1'b1;
        #1;
        check("byp_dat", 32'(oRdDat), 32'hAA);
        @(posedge clk);
        #2;
        check("byp_cnt", 32'(oCnt), 32'd0);
        check("byp_udf", 32'(oUdf), 32'd0);
`else
        cyc(1'b0, 8'h00, 1'b1);
        check("udf_set", 32'(oUdf),   32'd1);
        check("udf_cnt", 32'(oCnt),   32'd0);
        check("udf_emp", 32'(oEmpty), 32'd1);
`endif
        cyc(1'b1, 8'h5A, 1'b0);
        check("post_udf_dat", 32'(oRdDat), 32'h5A);

        // Asynchronous reset mid-cycle at occupancy 3.
        do_reset();
        cyc(1'b1, 8'h41, 1'b0);
        cyc(1'b1, 8'h42, 1'b0);
        cyc(1'b1, 8'h43, 1'b0);
        check("pre_rst_cnt", 32'(oCnt), 32'd3);
        iWrEn = 1'b0;
        rst   = 1'b1;
        #1;
        check("async_empty", 32'(oEmpty), 32'd1);
        check("async_cnt",   32'(oCnt),   32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(1'b1, 8'h10, 1'b0);
        check("after_rst_dat",   32'(oRdDat), 32'h10);
        check("after_rst_empty", 32'(oEmpty), 32'd0);

        // Randomized traffic with phase-dependent write/read bias and rare async resets.
        for (int n = 0; n < 900; n++) begin
            int wr_pct;
            wr_pct = (((n / 100) % 3) == 0) ? 75 : ((((n / 100) % 3) == 1) ? 50 : 25);
            if ($urandom_range(0, 199) == 0) begin
                iWrEn = 1'b0;
                iRdEn = 1'b0;
                rst   = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                cyc($urandom_range(0, 99) < wr_pct, WIDTH'($urandom),
                    $urandom_range(0, 99) < (100 - wr_pct));
            end
        end

        iWrEn = 1'b0;
        iRdEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
